// File: rtl/mux_sel_scan_ctrl.sv
// mux_sel_scan_ctrl: upstream driver for a WIDTH-bit 2:1 select mux.
// Holds two committed operands (d0, d1), scans the mux select x once per
// DIV-cycle slot and drives active-low digit enables that track x.
// Operand writes land in shadow registers and are committed only when x
// wraps from slot 1 back to slot 0, so the mux never shows a mixed pair.
// Optional: define MUX_SEL_BLANK_EN to blank the enables for BLANK cycles
// after every select change (and for the first slot after reset).
module mux_sel_scan_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic             hold,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic             x,
  output logic [1:0]       an,
  output logic             tick,
  output logic             pending
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  // Reject parameter sets the scan cannot honour.
  if (DIV < 1 || BLANK >= DIV) begin : gen_bad_params
    $error("mux_sel_scan_ctrl: need DIV >= 1 and BLANK < DIV");
  end

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             x_q, x_d;
  logic [1:0]       an_q, an_d;
  logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic             pending_q, pending_d;
  logic             toggle, commit;
  logic [1:0]       an_sel;

`ifdef MUX_SEL_BLANK_EN
  localparam int unsigned BlankW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [BlankW-1:0] BlankInit = (BLANK > 0) ? BlankW'(BLANK - 1) : '0;
  logic [BlankW-1:0] blank_q, blank_d;
`endif

  // Prescaler, select toggle, frame commit and shadow load.
  always_comb begin
    cnt_d     = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    tick_d    = (cnt_q == CntMax);
    // A tick under hold is consumed without moving the select.
    toggle    = tick_q & ~hold;
    x_d       = x_q ^ toggle;
    // Commit only on the 1->0 wrap, i.e. at the end of a full frame.
    commit    = toggle & x_q & pending_q;
    // Commit takes the pre-edge shadow; a coincident load refills it.
    d0_d      = commit ? sh0_q : d0_q;
    d1_d      = commit ? sh1_q : d1_q;
    sh0_d     = load ? din0 : sh0_q;
    sh1_d     = load ? din1 : sh1_q;
    pending_d = load | (pending_q & ~commit);
    an_sel    = x_d ? 2'b01 : 2'b10;
  end

`ifdef MUX_SEL_BLANK_EN
  // Enable generation with post-toggle blanking window.
  always_comb begin
    blank_d = blank_q;
    an_d    = an_sel;
    if (toggle) begin
      blank_d = BlankInit;
      an_d    = (BLANK == 0) ? an_sel : 2'b11;
    end else if (blank_q != '0) begin
      blank_d = blank_q - 1'b1;
      an_d    = 2'b11;
    end
  end

  // Blank counter state; the first slot after reset starts blanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= BlankInit;
    end else begin
      blank_q <= blank_d;
    end
  end
`else
  // Enables follow the next select value directly.
  always_comb begin
    an_d = an_sel;
  end
`endif

  // State registers; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      x_q       <= 1'b0;
      an_q      <= 2'b11;
      d0_q      <= '0;
      d1_q      <= '0;
      sh0_q     <= '0;
      sh1_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      x_q       <= x_d;
      an_q      <= an_d;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      sh0_q     <= sh0_d;
      sh1_q     <= sh1_d;
      pending_q <= pending_d;
    end
  end

  assign d0      = d0_q;
  assign d1      = d1_q;
  assign x       = x_q;
  assign an      = an_q;
  assign tick    = tick_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_mux_sel_scan_ctrl.sv
// Directed bench for mux_sel_scan_ctrl with DIV=4, WIDTH=4, BLANK=1.
// A run-length vector table walks scan, commit, overwrite, coincident load
// and hold; hand-written sequences cover reset state and async mid-slot reset.
module tb_mux_sel_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] din0, din1;
  logic       hold;
  logic [3:0] d0, d1;
  logic       x;
  logic [1:0] an;
  logic       tick;
  logic       pending;

  int checks;
  int errors;

  mux_sel_scan_ctrl #(
    .WIDTH(4),
    .DIV  (4),
    .BLANK(1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .din0   (din0),
    .din1   (din1),
    .hold   (hold),
    .d0     (d0),
    .d1     (d1),
    .x      (x),
    .an     (an),
    .tick   (tick),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         reps;
    logic       load;
    logic [3:0] din0;
    logic [3:0] din1;
    logic       hold;
    logic [3:0] e_d0;
    logic [3:0] e_d1;
    logic       e_x;
    logic [1:0] e_an;
    logic       e_tick;
    logic       e_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int reps, input logic ld, input logic [3:0] a, input logic [3:0] b,
                     input logic hd, input logic [3:0] ed0, input logic [3:0] ed1,
                     input logic ex, input logic [1:0] ean, input logic et, input logic ep);
    vec_t v;
    v.reps = reps; v.load = ld; v.din0 = a; v.din1 = b; v.hold = hd;
    v.e_d0 = ed0; v.e_d1 = ed1; v.e_x = ex; v.e_an = ean; v.e_tick = et; v.e_pend = ep;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // With blanking, the cycle right after an x change shows 2'b11.
  function automatic logic [1:0] exp_an(input logic [1:0] base, input logic ex,
                                        input logic prev_x);
`ifdef MUX_SEL_BLANK_EN
    if (ex != prev_x) return 2'b11;
`endif
    return base;
  endfunction

  initial begin
    logic prev_x;
    int   edge_n;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    load   = 1'b0;
    hold   = 1'b0;
    din0   = 4'h0;
    din1   = 4'h0;

    //     reps ld din0  din1  hd  d0    d1    x  an     tk pend
    add(3, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 2'b10, 0, 0);  // edges 1-3
    add(1, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 2'b10, 1, 0);  // 4
    add(3, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 2'b01, 0, 0);  // 5-7
    add(1, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 2'b01, 1, 0);  // 8
    add(1, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 2'b10, 0, 0);  // 9 (nothing to commit)
    add(1, 1, 4'hA, 4'h5, 0, 4'h0, 4'h0, 0, 2'b10, 0, 1);  // 10 load A/5
    add(1, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 2'b10, 0, 1);  // 11
    add(1, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 2'b10, 1, 1);  // 12
    add(3, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 2'b01, 0, 1);  // 13-15 no commit on 0->1
    add(1, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 2'b01, 1, 1);  // 16
    add(2, 0, 4'h0, 4'h0, 0, 4'hA, 4'h5, 0, 2'b10, 0, 0);  // 17-18 commit A/5
    add(1, 1, 4'h1, 4'h2, 0, 4'hA, 4'h5, 0, 2'b10, 0, 1);  // 19 load 1/2
    add(1, 0, 4'h0, 4'h0, 0, 4'hA, 4'h5, 0, 2'b10, 1, 1);  // 20
    add(1, 1, 4'h3, 4'h4, 0, 4'hA, 4'h5, 1, 2'b01, 0, 1);  // 21 overwrite 3/4
    add(2, 0, 4'h0, 4'h0, 0, 4'hA, 4'h5, 1, 2'b01, 0, 1);  // 22-23
    add(1, 0, 4'h0, 4'h0, 0, 4'hA, 4'h5, 1, 2'b01, 1, 1);  // 24
    add(1, 1, 4'h7, 4'h8, 0, 4'h3, 4'h4, 0, 2'b10, 0, 1);  // 25 commit + coincident load
    add(2, 0, 4'h0, 4'h0, 0, 4'h3, 4'h4, 0, 2'b10, 0, 1);  // 26-27
    add(1, 0, 4'h0, 4'h0, 0, 4'h3, 4'h4, 0, 2'b10, 1, 1);  // 28
    add(3, 0, 4'h0, 4'h0, 0, 4'h3, 4'h4, 1, 2'b01, 0, 1);  // 29-31
    add(1, 0, 4'h0, 4'h0, 0, 4'h3, 4'h4, 1, 2'b01, 1, 1);  // 32
    add(2, 0, 4'h0, 4'h0, 0, 4'h7, 4'h8, 0, 2'b10, 0, 0);  // 33-34 commit 7/8
    add(1, 1, 4'h9, 4'h6, 0, 4'h7, 4'h8, 0, 2'b10, 0, 1);  // 35 load 9/6
    add(1, 0, 4'h0, 4'h0, 0, 4'h7, 4'h8, 0, 2'b10, 1, 1);  // 36
    add(1, 0, 4'h0, 4'h0, 0, 4'h7, 4'h8, 1, 2'b01, 0, 1);  // 37
    add(2, 0, 4'h0, 4'h0, 1, 4'h7, 4'h8, 1, 2'b01, 0, 1);  // 38-39 hold
    add(1, 0, 4'h0, 4'h0, 1, 4'h7, 4'h8, 1, 2'b01, 1, 1);  // 40
    add(3, 0, 4'h0, 4'h0, 1, 4'h7, 4'h8, 1, 2'b01, 0, 1);  // 41-43 tick 1 consumed
    add(1, 0, 4'h0, 4'h0, 1, 4'h7, 4'h8, 1, 2'b01, 1, 1);  // 44
    add(3, 0, 4'h0, 4'h0, 1, 4'h7, 4'h8, 1, 2'b01, 0, 1);  // 45-47 tick 2 consumed
    add(1, 0, 4'h0, 4'h0, 1, 4'h7, 4'h8, 1, 2'b01, 1, 1);  // 48
    add(1, 0, 4'h0, 4'h0, 1, 4'h7, 4'h8, 1, 2'b01, 0, 1);  // 49 tick 3 consumed
    add(2, 0, 4'h0, 4'h0, 0, 4'h7, 4'h8, 1, 2'b01, 0, 1);  // 50-51 hold released
    add(1, 0, 4'h0, 4'h0, 0, 4'h7, 4'h8, 1, 2'b01, 1, 1);  // 52
    add(3, 0, 4'h0, 4'h0, 0, 4'h9, 4'h6, 0, 2'b10, 0, 0);  // 53-55 commit 9/6
    add(1, 0, 4'h0, 4'h0, 0, 4'h9, 4'h6, 0, 2'b10, 1, 0);  // 56

    // Reset state while clock runs with rst_n low.
    #12;
    chk("rst d0", 8'(d0), 8'h0);
    chk("rst d1", 8'(d1), 8'h0);
    chk("rst x", 8'(x), 8'h0);
    chk("rst an", 8'(an), 8'h3);
    chk("rst tick", 8'(tick), 8'h0);
    chk("rst pending", 8'(pending), 8'h0);
    #6 rst_n = 1'b1;

    prev_x = 1'b0;
    edge_n = 0;
    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        load = vecs[i].load;
        din0 = vecs[i].din0;
        din1 = vecs[i].din1;
        hold = vecs[i].hold;
        @(posedge clk);
        #1;
        edge_n++;
        chk($sformatf("e%0d d0", edge_n), 8'(d0), 8'(vecs[i].e_d0));
        chk($sformatf("e%0d d1", edge_n), 8'(d1), 8'(vecs[i].e_d1));
        chk($sformatf("e%0d x", edge_n), 8'(x), 8'(vecs[i].e_x));
        chk($sformatf("e%0d an", edge_n), 8'(an),
            8'(exp_an(vecs[i].e_an, vecs[i].e_x, prev_x)));
        chk($sformatf("e%0d tick", edge_n), 8'(tick), 8'(vecs[i].e_tick));
        chk($sformatf("e%0d pending", edge_n), 8'(pending), 8'(vecs[i].e_pend));
        prev_x = vecs[i].e_x;
      end
    end
    load = 1'b0;
    hold = 1'b0;

    // Edge 57 moves to slot 1; edge 58 loads data that must be lost on reset.
    @(posedge clk);
    #1;
    load = 1'b1;
    din0 = 4'h5;
    din1 = 4'hC;
    @(posedge clk);
    #1;
    load = 1'b0;
    chk("pre-rst x", 8'(x), 8'h1);
    chk("pre-rst pending", 8'(pending), 8'h1);

    // Async reset between edges: outputs clear with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async d0", 8'(d0), 8'h0);
    chk("async d1", 8'(d1), 8'h0);
    chk("async x", 8'(x), 8'h0);
    chk("async an", 8'(an), 8'h3);
    chk("async tick", 8'(tick), 8'h0);
    chk("async pending", 8'(pending), 8'h0);
    #4 rst_n = 1'b1;

    // Restart: full 4-cycle first slot, shadow data gone at the first frame end.
    prev_x = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      logic ex;
      @(posedge clk);
      #1;
      ex = (k >= 5 && k <= 8);
      chk($sformatf("post-rst k%0d tick", k), 8'(tick), 8'((k == 4) || (k == 8)));
      chk($sformatf("post-rst k%0d x", k), 8'(x), 8'(ex));
      chk($sformatf("post-rst k%0d an", k), 8'(an),
          8'(exp_an(ex ? 2'b01 : 2'b10, ex, prev_x)));
      chk($sformatf("post-rst k%0d pending", k), 8'(pending), 8'h0);
      chk($sformatf("post-rst k%0d d0", k), 8'(d0), 8'h0);
      chk($sformatf("post-rst k%0d d1", k), 8'(d1), 8'h0);
      prev_x = ex;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_scan_ctrl.md
Name: mux_sel_scan_ctrl

Overview:
- Upstream driver for the 4-bit 2:1 select mux stage.
- Holds the two 4-bit operands presented on the mux data inputs (d0, d1) and generates the mux select (x) as a periodic scan.
- Drives two active-low digit enables that track the select, for time-multiplexed two-digit display use.
- Operand updates are double-buffered and committed only at frame boundaries, so the mux never shows a mixed old/new pair.

Parameters:
- WIDTH, 4: operand width; must match the mux data width.
- DIV, 50000: clock cycles per scan slot; legal range >= 1.
- BLANK, 16: enable-off cycles after each select change; used only with MUX_SEL_BLANK_EN; must be < DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  write strobe for the shadow operand registers.
- din0  in  WIDTH  new operand for slot 0.
- din1  in  WIDTH  new operand for slot 1.
- hold  in  1  freezes the select toggle while high.
- d0  out  WIDTH  committed slot-0 operand; connects to mux d0.
- d1  out  WIDTH  committed slot-1 operand; connects to mux d1.
- x  out  1  mux select; 0 selects d0, 1 selects d1.
- an  out  2  active-low digit enables; an[0] is slot 0, an[1] is slot 1.
- tick  out  1  one-cycle pulse at the end of each scan slot.
- pending  out  1  shadow holds data not yet committed.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low. All state is cleared immediately on rst_n=0, independent of clk.
- Reset values:
  - d0 = 0, d1 = 0, x = 0, an = 2'b11, tick = 0, pending = 0.
  - Shadow registers = 0.
  - Prescaler count = 0.
- Prescaler:
  - Counter cnt runs 0..DIV-1 and wraps to 0. Width is clog2(DIV), minimum 1.
  - tick is registered: it is 1 in the cycle after the edge at which cnt == DIV-1.
  - Effective period is DIV cycles. With DIV=1, tick is high every cycle after reset.
  - The prescaler always runs, including when hold=1.
- Select:
  - On any edge where tick is 1 and hold is 0, x toggles.
  - With hold=1, x is frozen and the tick is consumed with no effect.
- Frame commit:
  - A commit occurs on the edge where x toggles 1->0, and only if pending=1.
  - On commit: d0 <= shadow0, d1 <= shadow1, pending <= 0.
  - A commit never happens on a 0->1 toggle.
- Load:
  - On an edge where load=1: shadow0 <= din0, shadow1 <= din1, pending <= 1.
  - Back-to-back loads overwrite the shadow; only the last load before a commit is committed.
- Load coincident with a commit edge:
  - The commit uses the shadow values as they were before that edge.
  - The new din values are written to the shadow, and pending stays 1.
- Enables:
  - an is registered and updates on the same edge as x.
  - Next value: an = 2'b10 when next x = 0, and 2'b01 when next x = 1.
  - First edge after reset release: an = 2'b10.
- Reset mid-slot: all of the above is cleared, including any pending shadow data. Scanning restarts from slot 0 with a full DIV-cycle slot.
- Outputs d0, d1 and x are glitch-free registers and change only on clk edges.
- Mux path latency: x and the operands reach mux output y combinationally, in the same cycle.

Optional Feature:
- Macro: MUX_SEL_BLANK_EN.
- When defined:
  - After each edge where x toggles, an is forced to 2'b11 for BLANK cycles.
  - It then takes the value selected by x.
  - A blank counter is reset on every toggle.
  - After reset, the first slot is also blanked for BLANK cycles.
  - x, d0, d1, tick and pending are unaffected.
- When undefined: no blank counter exists; an follows x exactly as described in Behaviour.

Test Plan (DIV=4, WIDTH=4, BLANK=1 where applicable):
- Reset scan: release rst_n, hold=0, no load -> tick pulses every 4 cycles; x toggles on each tick (0,1,0,...); an alternates 2'b10/2'b01 in step with x; d0 = d1 = 0.
- Frame commit: while x=0, load=1 with din0=4'hA, din1=4'h5 -> pending=1; d0/d1 stay 0 across the 0->1 toggle; on the next 1->0 toggle d0=4'hA, d1=4'h5 and pending=0.
- Overwrite and coincident load:
  - Two loads (4'h1/4'h2, then 4'h3/4'h4) before a frame end -> commit shows 4'h3/4'h4.
  - A load of 4'h7/4'h8 on the exact commit edge -> d0/d1 = 4'h3/4'h4, pending stays 1, and 4'h7/4'h8 commit one frame later.
- Hold: assert hold for 3 ticks while x=1 -> x stays 1, an stays 2'b01, and no commit occurs despite pending=1; deassert hold -> the next tick sets x=0 and commits.
- Async reset mid-slot: drop rst_n between edges with pending=1 and x=1 -> outputs reach their reset values immediately without a clk edge; after release the shadow data is lost (d0 = d1 = 0).
- MUX_SEL_BLANK_EN defined -> an = 2'b11 for exactly 1 cycle after each x toggle, then the correct enable; without the macro, an never shows 2'b11 after the first clk edge following reset release.
